fact_bcd_conv: RTL and testbench

Downstream result formatter for the factorial accelerator. It watches the accelerator's `done` and `result` outputs and converts each newly completed 32-bit result into 10 packed BCD digits using a sequential shift-and-add-3 (double-dabble) engine. It also reports the count of significant digits for the display and readback logic. The converter is sequential: one bit per cycle, with no combinational divide.

---
 rtl/fact_bcd_conv.sv | 107 ++++++++++
 tb/tb_fact_bcd_conv.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fact_bcd_conv.sv
// Result formatter for the factorial accelerator: converts each newly completed
// binary result to packed BCD with a one-bit-per-cycle double-dabble engine.
module fact_bcd_conv #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  done_in,
  input  logic [WIDTH-1:0]      result_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic [3:0]            digit_count
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state;
  logic               done_d;
  logic [WIDTH-1:0]   bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic [CNT_W-1:0]   cnt;
  logic               req;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W+WIDTH-1:0] shifted;

  // Pre-shift correction: digits of 5 or more get +3 so they carry correctly
  // into the next digit once doubled; 4-bit add, no inter-digit carry.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    logic [3:0]       d;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      d = s[4*i +: 4];
      if (d >= 4'd5) r[4*i +: 4] = d + 4'd3;
    end
    return r;
  endfunction

  // Highest nonzero digit position plus one; an all-zero value still shows one digit.
  function automatic logic [3:0] count_digits(input logic [BCD_W-1:0] b);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

  assign req         = done_in & ~done_d;
  assign scratch_adj = dabble_adjust(scratch);
  assign shifted     = {scratch_adj, bin_sr} << 1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done_d      <= 1'b0;
      bin_sr      <= '0;
      scratch     <= '0;
      cnt         <= '0;
      bcd         <= '0;
      bcd_valid   <= 1'b0;
      busy        <= 1'b0;
      digit_count <= 4'd0;
    end else begin
      done_d <= done_in;
      case (state)
        IDLE: begin
          if (req) begin
            bin_sr    <= result_in;
            scratch   <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            bcd_valid <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[BCD_W+WIDTH-1:WIDTH];
          bin_sr  <= shifted[WIDTH-1:0];
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
        end
        FINISH: begin
          bcd         <= scratch;
          digit_count <= count_digits(scratch);
          bcd_valid   <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_bcd_conv.sv
// Directed bench for fact_bcd_conv: fixed-latency conversions, edge detection,
// ignored requests while busy and asynchronous reset mid-conversion.
module tb_fact_bcd_conv;

  logic        clk;
  logic        reset;
  logic        done_in;
  logic [31:0] result_in;
  logic [39:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic [3:0]  digit_count;

  int n_cmp;
  int n_bad;

  fact_bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .done_in     (done_in),
    .result_in   (result_in),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid),
    .busy        (busy),
    .digit_count (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ".bcd"},   64'(bcd),         64'h0);
    chk({tag, ".valid"}, 64'(bcd_valid),   64'h0);
    chk({tag, ".busy"},  64'(busy),        64'h0);
    chk({tag, ".dc"},    64'(digit_count), 64'h0);
  endtask

  // Pulse a request, then check the exact 33-cycle latency and final outputs.
  task automatic conv(input string tag, input logic [31:0] v,
                      input logic [39:0] exp_bcd, input logic [3:0] exp_dc);
    result_in = v;
    done_in   = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    chk({tag, ".busy_start"},  64'(busy),      64'h1);
    chk({tag, ".valid_start"}, 64'(bcd_valid), 64'h0);
    repeat (32) @(negedge clk);
    chk({tag, ".busy_k32"},  64'(busy),      64'h1);
    chk({tag, ".valid_k32"}, 64'(bcd_valid), 64'h0);
    @(negedge clk);
    chk({tag, ".bcd"},   64'(bcd),         64'(exp_bcd));
    chk({tag, ".dc"},    64'(digit_count), 64'(exp_dc));
    chk({tag, ".valid"}, 64'(bcd_valid),   64'h1);
    chk({tag, ".busy"},  64'(busy),        64'h0);
  endtask

  initial begin
    int busy_rises;
    logic busy_prev;
    int waited;

    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b0;
    done_in   = 1'b0;
    result_in = '0;
    #1;
    chk_zero_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    conv("one",   32'd1,         40'h00_0000_0001, 4'd1);
    // The following calls start right at edge k+34: the earliest accepted request.
    conv("fact12", 32'd479001600, 40'h04_7900_1600, 4'd9);
    conv("zero",   32'd0,         40'h00_0000_0000, 4'd1);
    conv("max",    32'hFFFF_FFFF, 40'h42_9496_7295, 4'd10);
    conv("nines",  32'd999999999, 40'h09_9999_9999, 4'd9);

    // Level held high for 100 cycles yields a single conversion.
    @(negedge clk);
    result_in  = 32'd120;
    done_in    = 1'b1;
    busy_rises = 0;
    busy_prev  = busy;
    repeat (100) begin
      @(negedge clk);
      if (busy && !busy_prev) busy_rises++;
      busy_prev = busy;
    end
    done_in = 1'b0;
    chk("hold.busy_pulses", 64'(busy_rises), 64'd1);
    chk("hold.bcd",   64'(bcd),         64'h120);
    chk("hold.dc",    64'(digit_count), 64'd3);
    chk("hold.busy",  64'(busy),        64'h0);

    // A fresh edge during the conversion is dropped, not queued.
    @(negedge clk);
    result_in = 32'd5040;
    done_in   = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    repeat (9) @(negedge clk);
    result_in = 32'd720;
    done_in   = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    waited = 0;
    while (!bcd_valid && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    chk("ignore.timeout", 64'(bcd_valid), 64'h1);
    chk("ignore.bcd", 64'(bcd),         64'h5040);
    chk("ignore.dc",  64'(digit_count), 64'd4);
    repeat (5) @(negedge clk);
    chk("ignore.no_requeue", 64'(busy), 64'h0);
    chk("ignore.bcd_hold",   64'(bcd),  64'h5040);

    // Asynchronous reset mid-conversion clears everything at once.
    result_in = 32'd40320;
    done_in   = 1'b1;
    @(negedge clk);
    done_in = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort.busy_before", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    chk_zero_outputs("abort");
    repeat (2) @(negedge clk);
    chk_zero_outputs("abort_hold");
    reset = 1'b1;
    @(negedge clk);
    chk("abort.idle_after", 64'(busy), 64'h0);
    conv("six", 32'd6, 40'h00_0000_0006, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
